alu_seq: RTL and testbench

- Sequential front end for the 12-bit combinational ALU (inputs A, B, OP; outputs Z, CarryOut, Sign, OV).
- Accepts operation commands over a valid/ready handshake and drives registered operands and opcode into the ALU.
- Waits a fixed settle time, then captures Z and the flags into a result register.
- Presents the result on a valid/ready output port and counts completed operations.

---
 rtl/alu_seq.sv | 135 +++++++++++++
 tb/tb_alu_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential front end for a 12-bit combinational ALU.
// Accepts a command over valid/ready and drives registered operands and the
// opcode into the ALU. After SETTLE cycles it captures Z and the flags into a
// result register and offers the result on a valid/ready port.
// Optional feature macro: ALU_SEQ_CHAIN_EN adds cmd_chain. When cmd_chain is 1,
// operand A is taken from the previous res_z.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | cmd_ready high, waiting for cmd_valid
// DRIVE | operands held on the ALU, settle counter running down
// HOLD  | result captured, res_valid high, waiting for res_ready
module alu_seq #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [11:0] cmd_a,
    input  logic [11:0] cmd_b,
`ifdef ALU_SEQ_CHAIN_EN
    input  logic        cmd_chain,
`endif
    output logic [11:0] alu_a,
    output logic [11:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [11:0] alu_z,
    input  logic        alu_carry,
    input  logic        alu_sign,
    input  logic        alu_ov,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [11:0] res_z,
    output logic [3:0]  res_flags,
    output logic [7:0]  op_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    // SETTLE is 1..15, so the reload value always fits in four bits
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

    logic [1:0]  state;
    logic [1:0]  next_state;
    logic [3:0]  settle_cnt;
    logic        accept;
    logic        capture;
    logic        done;
    logic [11:0] a_sel;

    assign accept  = (state == IDLE) && cmd_valid && cmd_ready;
    assign capture = (state == DRIVE) && (settle_cnt == 4'd0);
    assign done    = (state == HOLD) && res_ready;

`ifdef ALU_SEQ_CHAIN_EN
    assign a_sel = cmd_chain ? res_z : cmd_a;
`else
    assign a_sel = cmd_a;
`endif

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)  next_state = DRIVE;
            DRIVE:   if (capture) next_state = HOLD;
            HOLD:    if (done)    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register; cmd_ready is registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
        end else begin
            state     <= next_state;
            cmd_ready <= (next_state == IDLE);
        end
    end

    // ALU operand and opcode registers, loaded only on acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a  <= 12'h000;
            alu_b  <= 12'h000;
            alu_op <= 3'd0;
        end else if (accept) begin
            alu_a  <= a_sel;
            alu_b  <= cmd_b;
            alu_op <= cmd_op;
        end
    end

    // Settle down-counter; reaching zero in DRIVE triggers the capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= 4'd0;
        end else if (accept) begin
            settle_cnt <= SETTLE_LD;
        end else if ((state == DRIVE) && (settle_cnt != 4'd0)) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    // Result register and valid flag; the zero flag is derived from the captured Z
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_z     <= 12'h000;
            res_flags <= 4'b0000;
        end else if (capture) begin
            res_valid <= 1'b1;
            res_z     <= alu_z;
            res_flags <= {alu_ov, alu_sign, alu_carry, (alu_z == 12'h000)};
        end else if (done) begin
            res_valid <= 1'b0;
        end
    end

    // Completed-operation counter, wraps at 255
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= 8'd0;
        end else if (done) begin
            op_count <= op_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq with a golden ALU model and a result scoreboard.
module tb_alu_seq;

    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [11:0] cmd_a = 12'h000;
    logic [11:0] cmd_b = 12'h000;
`ifdef ALU_SEQ_CHAIN_EN
    logic        cmd_chain = 1'b0;
`endif
    logic [11:0] alu_a, alu_b;
    logic [2:0]  alu_op;
    logic [11:0] alu_z;
    logic        alu_carry, alu_sign, alu_ov;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [11:0] res_z;
    logic [3:0]  res_flags;
    logic [7:0]  op_count;

    typedef struct packed {
        logic [11:0] z;
        logic [3:0]  f;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [7:0]  exp_cnt = 8'd0;
    logic [11:0] last_z = 12'h000;
    logic [3:0]  last_f = 4'h0;

    always #5 clk = ~clk;

    alu_seq #(.SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
`ifdef ALU_SEQ_CHAIN_EN
        .cmd_chain(cmd_chain),
`endif
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_z(alu_z), .alu_carry(alu_carry), .alu_sign(alu_sign), .alu_ov(alu_ov),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_z(res_z), .res_flags(res_flags), .op_count(op_count)
    );

    // Golden ALU: returns {z, carry, sign, ov}
    function automatic logic [14:0] alu_model(input logic [2:0] op, input logic [11:0] a, input logic [11:0] b);
        logic [12:0] s;
        logic [11:0] z;
        logic        c, ov;
        s = 13'h0; z = 12'h0; c = 1'b0; ov = 1'b0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; z = s[11:0]; c = s[12]; ov = (a[11] == b[11]) && (z[11] != a[11]); end
            3'd1: begin s = {1'b0, a} - {1'b0, b}; z = s[11:0]; c = s[12]; ov = (a[11] != b[11]) && (z[11] != a[11]); end
            3'd2: z = a & b;
            3'd3: z = a | b;
            3'd4: z = a ^ b;
            3'd5: z = ~a;
            3'd6: begin z = {a[10:0], 1'b0}; c = a[11]; end
            default: begin z = {1'b0, a[11:1]}; c = a[0]; end
        endcase
        return {z, c, z[11], ov};
    endfunction

    always_comb {alu_z, alu_carry, alu_sign, alu_ov} = alu_model(alu_op, alu_a, alu_b);

    function automatic exp_t expect_of(input logic [2:0] op, input logic [11:0] a, input logic [11:0] b);
        logic [14:0] m;
        exp_t e;
        m = alu_model(op, a, b);
        e.z = m[14:3];
        e.f = {m[0], m[1], m[2], (m[14:3] == 12'h000)};
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one command once cmd_ready is seen; returns just after the acceptance edge
    task automatic send(input logic [2:0] op, input logic [11:0] a, input logic [11:0] b, input logic chain);
        int n;
        logic [11:0] eff_a;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        eff_a = chain ? last_z : a;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
`ifdef ALU_SEQ_CHAIN_EN
        cmd_chain = chain;
`endif
        sb.push_back(expect_of(op, eff_a, b));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
        cmd_chain = 1'b0;
`endif
        check("alu_a", alu_a, eff_a);
        check("alu_b", alu_b, b);
        check("alu_op", alu_op, op);
        check("cmd_ready_low", cmd_ready, 0);
    endtask

    // Must be called right after send; checks latency, result, backpressure and handshake
    task automatic get_result(input int stall);
        int n;
        exp_t e;
        logic [11:0] held_a;
        n = 0;
        while (!res_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, SETTLE);
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL sb_underflow: observed 0 entries expected 1");
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        check("res_z", res_z, e.z);
        check("res_flags", res_flags, e.f);
        last_z = res_z;
        last_f = res_flags;
        held_a = alu_a;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check("bp_res_valid", res_valid, 1);
            check("bp_res_z", res_z, e.z);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_alu_a", alu_a, held_a);
            check("bp_op_count", op_count, exp_cnt);
            cmd_valid = 1'b1;
            cmd_a = 12'($urandom);
            cmd_b = 12'($urandom);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        check("hs_res_valid", res_valid, 0);
        check("hs_op_count", op_count, exp_cnt);
        check("hs_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #2;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_z", res_z, 0);
        check("rst_res_flags", res_flags, 0);
        check("rst_op_count", op_count, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_cmd_ready_before_edge", cmd_ready, 0);
        @(posedge clk);
        #1;
        check("rel_cmd_ready_after_edge", cmd_ready, 1);

        // AND pass-through
        send(3'd2, 12'hF0F, 12'h0FF, 1'b0);
        get_result(0);
        check("and_z", last_z, 12'h00F);
        check("and_flags", last_f, 4'b0000);

        // Add with carry out to zero
        send(3'd0, 12'hFFF, 12'h001, 1'b0);
        get_result(0);
        check("add_z", last_z, 12'h000);
        check("add_flags", last_f, 4'b0011);
        check("add_count", op_count, 8'd2);

        // Backpressure with ignored cmd_valid pulses
        send(3'd4, 12'hA5A, 12'h3C3, 1'b0);
        get_result(5);

        // res_ready held high while no result is pending
        res_ready = 1'b1;
        send(3'd1, 12'h800, 12'h001, 1'b0);
        check("early_ready_count", op_count, exp_cnt);
        get_result(0);

        // Every opcode with random operands
        for (int i = 0; i < 8; i++) begin
            send(3'(i), 12'($urandom), 12'($urandom), 1'b0);
            get_result(0);
        end

        // Reset two cycles into DRIVE
        send(3'd0, 12'h123, 12'h456, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_cmd_ready", cmd_ready, 0);
        check("mid_rst_alu_a", alu_a, 0);
        check("mid_rst_alu_b", alu_b, 0);
        check("mid_rst_alu_op", alu_op, 0);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_res_z", res_z, 0);
        check("mid_rst_res_flags", res_flags, 0);
        check("mid_rst_op_count", op_count, 0);
        sb.delete();
        exp_cnt = 8'd0;
        last_z = 12'h000;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rel_cmd_ready_before_edge", cmd_ready, 0);
        @(posedge clk);
        #1;
        check("mid_rel_cmd_ready_after_edge", cmd_ready, 1);

        // 256 completed operations wrap the counter
        for (int i = 0; i < 256; i++) begin
            send(3'($urandom), 12'($urandom), 12'($urandom), 1'b0);
            get_result(0);
        end
        check("wrap_count", op_count, 8'd0);

`ifdef ALU_SEQ_CHAIN_EN
        // Chained add reuses the previous result as operand A
        send(3'd0, 12'h010, 12'h005, 1'b0);
        get_result(0);
        check("chain_first_z", last_z, 12'h015);
        send(3'd0, 12'hFFF, 12'h001, 1'b1);
        check("chain_alu_a", alu_a, 12'h015);
        get_result(0);
        check("chain_second_z", last_z, 12'h016);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
